// File: rtl/uart_msg_echo_ctrl.sv
// ---------------------------------------------------------------------------
// uart_msg_echo_ctrl
//   Transmit arbiter between uart_rx and uart_tx. Every PERIOD_CYC cycles a
//   fixed banner (MSG, most-significant byte first) is sent. Between banners,
//   received bytes are buffered in a FIFO_DEPTH-entry RX FIFO and echoed in
//   order. A banner starts only at a byte boundary and is never interleaved
//   with echo bytes.
//
//   Optional feature macro: UART_ECHO_CASE_SWAP_EN
//     defined   -> echoed ASCII letters leave with bit 5 inverted (case swap)
//     undefined -> echoed bytes are sent verbatim
//
// Ports
//   clk, rst_n   clock, asynchronous active-low reset
//   recv_en      1-cycle strobe, recv_data valid (from uart_rx)
//   recv_data    received byte
//   send_busy    uart_tx busy (rises the cycle after send_en)
//   send_en      1-cycle strobe, uart_tx latches send_data
//   send_data    byte to transmit
//   fifo_level   RX FIFO occupancy, 0..FIFO_DEPTH
//   ovf          sticky: a byte was dropped on a full FIFO
//   ovf_clr      synchronous clear of ovf (a coincident overflow wins)
//   msg_active   high from the first banner strobe until the last byte drains
// ---------------------------------------------------------------------------
module uart_msg_echo_ctrl #(
  parameter int unsigned          CLK_FRE    = 50,
  parameter int unsigned          PERIOD_CYC = CLK_FRE * 1000000,
  parameter int unsigned          MSG_LEN    = 13,
  parameter logic [MSG_LEN*8-1:0] MSG        = "Hello World\r\n",
  parameter int unsigned          FIFO_DEPTH = 16,
  parameter int unsigned          LVL_W      = $clog2(FIFO_DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             recv_en,
  input  logic [7:0]       recv_data,
  input  logic             send_busy,
  output logic             send_en,
  output logic [7:0]       send_data,
  output logic [LVL_W-1:0] fifo_level,
  output logic             ovf,
  input  logic             ovf_clr,
  output logic             msg_active
);

  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned CNT_W = $clog2(PERIOD_CYC);
  localparam int unsigned IDX_W = 8;

  typedef enum logic [2:0] {
    IDLE,
    SEL_MSG,
    SEL_ECHO,
    ACK,
    DRAIN
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] idx;
  logic             msg_req;
  logic [CNT_W-1:0] cnt;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;

  logic             wrap_c;
  logic             full_c;
  logic             msg_go_c;
  logic             pop_c;
  logic             push_c;
  logic [7:0]       head_c;

  // Banner byte i, counted from the most-significant end of MSG.
  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] i);
    msg_byte = 8'(MSG >> (8 * (MSG_LEN - 1 - 32'(i))));
  endfunction

  // Transformation applied to echoed bytes only.
  function automatic logic [7:0] echo_byte(input logic [7:0] b);
`ifdef UART_ECHO_CASE_SWAP_EN
    if ((b >= 8'h61 && b <= 8'h7A) || (b >= 8'h41 && b <= 8'h5A))
      echo_byte = b ^ 8'h20;
    else
      echo_byte = b;
`else
    echo_byte = b;
`endif
  endfunction

  // Wrap is folded into the request so the first strobe lands on the wrap edge.
  always_comb begin
    wrap_c   = (cnt == CNT_W'(PERIOD_CYC - 1));
    full_c   = (fifo_level == LVL_W'(FIFO_DEPTH));
    msg_go_c = (state == IDLE) && !send_busy && (msg_req || wrap_c);
    pop_c    = (state == IDLE) && !send_busy && !(msg_req || wrap_c) &&
               (fifo_level != '0);
    push_c   = recv_en && (!full_c || pop_c);
    head_c   = mem[rd_ptr];
  end

  // Free-running banner period counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (wrap_c) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  // FIFO storage; contents are don't-care after reset because pointers clear.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= recv_data;
    end
  end

  // FIFO pointers, occupancy and sticky overflow.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_level <= '0;
      ovf        <= 1'b0;
    end else begin
      if (push_c) wr_ptr <= wr_ptr + AW'(1);
      if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
      case ({push_c, pop_c})
        2'b10:   fifo_level <= fifo_level + LVL_W'(1);
        2'b01:   fifo_level <= fifo_level - LVL_W'(1);
        default: fifo_level <= fifo_level;
      endcase
      if (recv_en && !push_c) begin
        ovf <= 1'b1;
      end else if (ovf_clr) begin
        ovf <= 1'b0;
      end
    end
  end

  // Transmit FSM; send_en is raised on entry to SEL_* so it is high for
  // exactly the SEL_* cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      idx        <= '0;
      msg_req    <= 1'b0;
      msg_active <= 1'b0;
      send_en    <= 1'b0;
      send_data  <= 8'h00;
    end else begin
      send_en <= 1'b0;
      // A wrap while a request is pending is absorbed.
      if (msg_go_c) begin
        msg_req <= 1'b0;
      end else if (wrap_c) begin
        msg_req <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (msg_go_c) begin
            idx        <= '0;
            msg_active <= 1'b1;
            send_data  <= msg_byte('0);
            send_en    <= 1'b1;
            state      <= SEL_MSG;
          end else if (pop_c) begin
            send_data <= echo_byte(head_c);
            send_en   <= 1'b1;
            state     <= SEL_ECHO;
          end
        end
        SEL_MSG, SEL_ECHO: begin
          state <= ACK;
        end
        ACK: begin
          state <= DRAIN;
        end
        DRAIN: begin
          if (!send_busy) begin
            if (msg_active) begin
              if (idx < IDX_W'(MSG_LEN - 1)) begin
                idx       <= idx + IDX_W'(1);
                send_data <= msg_byte(idx + IDX_W'(1));
                send_en   <= 1'b1;
                state     <= SEL_MSG;
              end else begin
                msg_active <= 1'b0;
                state      <= IDLE;
              end
            end else begin
              state <= IDLE;
            end
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_msg_echo_ctrl.sv
// ---------------------------------------------------------------------------
// tb_uart_msg_echo_ctrl
//   Directed bench for uart_msg_echo_ctrl with PERIOD_CYC=2000, MSG_LEN=13.
//   The uart_tx model is busy for 10 cycles after each send_en; tx_hold
//   forces it busy to fill the FIFO. Cycle numbers count posedges since the
//   most recent reset release.
// ---------------------------------------------------------------------------
module tb_uart_msg_echo_ctrl;

  localparam int unsigned PERIOD = 2000;
  localparam int unsigned LVL_W  = 5;

  logic             clk       = 1'b0;
  logic             rst_n     = 1'b0;
  logic             recv_en   = 1'b0;
  logic [7:0]       recv_data = 8'h00;
  logic             ovf_clr   = 1'b0;
  logic             send_busy;
  logic             send_en;
  logic [7:0]       send_data;
  logic [LVL_W-1:0] fifo_level;
  logic             ovf;
  logic             msg_active;

  int         n_cmp    = 0;
  int         n_err    = 0;
  int         cyc      = 0;
  int         busy_cnt = 0;
  logic       tx_hold  = 1'b0;
  logic       prev_en  = 1'b0;
  int         base     = 0;
  logic [7:0] tx_q  [$];
  logic       act_q [$];
  logic [103:0] banner = "Hello World\r\n";

  uart_msg_echo_ctrl #(
    .PERIOD_CYC (PERIOD),
    .MSG_LEN    (13),
    .FIFO_DEPTH (16)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .recv_en    (recv_en),
    .recv_data  (recv_data),
    .send_busy  (send_busy),
    .send_en    (send_en),
    .send_data  (send_data),
    .fifo_level (fifo_level),
    .ovf        (ovf),
    .ovf_clr    (ovf_clr),
    .msg_active (msg_active)
  );

  always #5 clk = ~clk;

  assign send_busy = (busy_cnt != 0) || tx_hold;

  // uart_tx model and cycle counter.
  always @(posedge clk) begin
    if (!rst_n) begin
      cyc      <= 0;
      busy_cnt <= 0;
    end else begin
      cyc <= cyc + 1;
      if (send_en) busy_cnt <= 10;
      else if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] bbyte(input int i);
    return banner[(12 - i) * 8 +: 8];
  endfunction

  function automatic logic [7:0] exp_echo(input logic [7:0] b);
`ifdef UART_ECHO_CASE_SWAP_EN
    if ((b >= 8'h61 && b <= 8'h7A) || (b >= 8'h41 && b <= 8'h5A)) return b ^ 8'h20;
    return b;
`else
    return b;
`endif
  endfunction

  // Strobe recorder and protocol checks.
  always @(negedge clk) begin
    if (rst_n) begin
      if (send_en) begin
        tx_q.push_back(send_data);
        act_q.push_back(msg_active);
        check("en_while_busy", 32'(send_busy), 0);
        check("en_consecutive", 32'(prev_en), 0);
      end
      prev_en = send_en;
    end else begin
      prev_en = 1'b0;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic goto(input int c);
    while (cyc < c) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_q(input int n, input int budget, input string tag);
    int t = 0;
    while (tx_q.size() < n && t < budget) begin
      @(posedge clk);
      #1;
      t++;
    end
    check(tag, 32'(tx_q.size()), 32'(n));
  endtask

  task automatic check_banner(input int b0, input string tag);
    for (int i = 0; i < 13; i++) begin
      check(tag, 32'(tx_q[b0 + i]), 32'(bbyte(i)));
      check("banner_active", 32'(act_q[b0 + i]), 1);
    end
  endtask

  initial begin
    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_send_en", 32'(send_en), 0);
    check("rst_send_data", 32'(send_data), 0);
    check("rst_level", 32'(fifo_level), 0);
    check("rst_ovf", 32'(ovf), 0);
    check("rst_msg_active", 32'(msg_active), 0);
    @(negedge clk);
    rst_n = 1'b1;

    // Idle echo latency: recv at 100 -> send_en at 102
    goto(100);
    recv_en = 1'b1; recv_data = 8'h41;
    step(1);
    recv_en = 1'b0;
    check("echo_lvl_1", 32'(fifo_level), 1);
    check("echo_no_early_en", 32'(send_en), 0);
    step(1);
    check("echo_en_102", 32'(send_en), 1);
    check("echo_data", 32'(send_data), 32'(exp_echo(8'h41)));
    check("echo_lvl_0", 32'(fifo_level), 0);

    // First banner exactly at cycle 2000
    goto(PERIOD - 1);
    check("pre_banner_en", 32'(send_en), 0);
    check("pre_banner_active", 32'(msg_active), 0);
    check("pre_banner_count", 32'(tx_q.size()), 1);
    base = tx_q.size();
    goto(PERIOD);
    check("banner_en_2000", 32'(send_en), 1);
    check("banner_byte0", 32'(send_data), 'h48);
    check("banner_active_on", 32'(msg_active), 1);

    // Bytes received during a banner wait until it completes
    for (int i = 0; i < 5; i++) begin
      recv_en = 1'b1; recv_data = 8'(8'h30 + i);
      step(1);
    end
    recv_en = 1'b0;
    check("mid_banner_lvl_5", 32'(fifo_level), 5);
    wait_q(base + 18, 600, "banner_echo_count");
    check_banner(base, "banner1_byte");
    for (int i = 0; i < 5; i++) begin
      check("post_banner_echo", 32'(tx_q[base + 13 + i]), 32'(8'h30 + i));
      check("echo_inactive", 32'(act_q[base + 13 + i]), 0);
    end
    step(20);
    check("after_banner_active", 32'(msg_active), 0);
    check("after_echo_lvl", 32'(fifo_level), 0);

    // Overflow: 20 bytes while tx is held busy
    goto(2400);
    tx_hold = 1'b1;
    base = tx_q.size();
    for (int i = 0; i < 20; i++) begin
      recv_en = 1'b1; recv_data = 8'(8'h80 + i);
      step(1);
    end
    recv_en = 1'b0;
    check("ovf_lvl_full", 32'(fifo_level), 16);
    check("ovf_set", 32'(ovf), 1);
    check("ovf_nothing_sent", 32'(tx_q.size()), 32'(base));
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_cleared", 32'(ovf), 0);
    check("ovf_lvl_kept", 32'(fifo_level), 16);
    recv_en = 1'b1; recv_data = 8'hEE; ovf_clr = 1'b1;
    step(1);
    recv_en = 1'b0; ovf_clr = 1'b0;
    check("ovf_set_wins", 32'(ovf), 1);
    check("ovf_lvl_still_full", 32'(fifo_level), 16);
    ovf_clr = 1'b1;
    step(1);
    ovf_clr = 1'b0;
    check("ovf_cleared_again", 32'(ovf), 0);
    tx_hold = 1'b0;
    wait_q(base + 16, 400, "ovf_echo_count");
    for (int i = 0; i < 16; i++) begin
      check("ovf_echo_byte", 32'(tx_q[base + i]), 32'(8'h80 + i));
    end
    step(40);
    check("ovf_no_extra", 32'(tx_q.size()), 32'(base + 16));
    check("ovf_lvl_drained", 32'(fifo_level), 0);

    // Banner and pending echo byte coincide in IDLE: banner first
    goto(2 * PERIOD - 2);
    base = tx_q.size();
    recv_en = 1'b1; recv_data = 8'h7A;
    step(1);
    recv_en = 1'b0;
    check("coinc_lvl_1", 32'(fifo_level), 1);
    check("coinc_no_en", 32'(send_en), 0);
    step(1);
    check("coinc_banner_en", 32'(send_en), 1);
    check("coinc_banner_byte0", 32'(send_data), 'h48);
    check("coinc_lvl_held", 32'(fifo_level), 1);
    wait_q(base + 14, 400, "coinc_count");
    check_banner(base, "banner2_byte");
    check("coinc_echo_last", 32'(tx_q[base + 13]), 32'(exp_echo(8'h7A)));
    check("coinc_echo_inactive", 32'(act_q[base + 13]), 0);

    // Reset during banner byte 6 with a byte queued
    goto(3 * PERIOD);
    check("b3_en", 32'(send_en), 1);
    base = tx_q.size();
    goto(3 * PERIOD + 65);
    recv_en = 1'b1; recv_data = 8'h55;
    step(1);
    recv_en = 1'b0;
    check("b3_lvl_1", 32'(fifo_level), 1);
    goto(3 * PERIOD + 74);
    check("b3_sent_7", 32'(tx_q.size()), 32'(base + 7));
    check("b3_byte6", 32'(tx_q[base + 6]), 'h57);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_send_en", 32'(send_en), 0);
    check("mid_rst_send_data", 32'(send_data), 0);
    check("mid_rst_level", 32'(fifo_level), 0);
    check("mid_rst_ovf", 32'(ovf), 0);
    check("mid_rst_active", 32'(msg_active), 0);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    base = tx_q.size();
    goto(PERIOD - 1);
    check("post_rst_quiet", 32'(tx_q.size()), 32'(base));
    check("post_rst_lvl", 32'(fifo_level), 0);
    goto(PERIOD);
    check("post_rst_banner_en", 32'(send_en), 1);
    check("post_rst_byte0", 32'(send_data), 'h48);
    wait_q(base + 13, 400, "post_rst_count");
    check_banner(base, "banner4_byte");
    step(40);
    check("post_rst_no_echo", 32'(tx_q.size()), 32'(base + 13));
    check("post_rst_inactive", 32'(msg_active), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
